// File: rtl/ula_port.sv
// ---------------------------------------------------------------------------
// ula_port -- Spectrum ULA I/O port (port 0xFE, any even address)
//
// Decodes Z80 I/O cycles to even addresses. It holds the border colour and
// the MIC/EAR output latches, and it assembles read data from the keyboard
// matrix and the synchronised tape input. It also produces a 1-bit audio
// stream for the beeper pin.
//
// The CPU strobes are sampled as plain levels in the clk domain, because
// cpuClock is only a divided enable-like clock.
//
// Build option:
//   ULA_SIGMA_DELTA_EN  defined   -> 9-bit first-order sigma-delta DAC
//                                    mixing EAR/MIC/tape levels
//                       undefined -> audio_out = reg(ear ^ (mic & ear_sync))
//
// Parameters:
//   EAR_LEVEL, MIC_LEVEL, TAPE_LEVEL  DAC weights (sum must be <= 255)
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   n_iorq     Z80 IORQ (active-low)
//   n_rd       Z80 RD (active-low)
//   n_wr       Z80 WR (active-low)
//   addr0      CPU address bit 0 (port selected when 0)
//   din[7:0]   CPU write data
//   key_data   keyboard columns, active-low
//   ear_in     asynchronous tape input
//   dout[7:0]  read data {1, ear_sync, 1, key_data}
//   rd_cs      port read in progress (combinational)
//   border     border colour latch
//   mic, ear   MIC / EAR latches
//   port_wr    one-clk pulse per accepted write
//   audio_out  audio bitstream
// ---------------------------------------------------------------------------
module ula_port #(
  parameter int unsigned EAR_LEVEL  = 192,
  parameter int unsigned MIC_LEVEL  = 32,
  parameter int unsigned TAPE_LEVEL = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       n_iorq,
  input  logic       n_rd,
  input  logic       n_wr,
  input  logic       addr0,
  input  logic [7:0] din,
  input  logic [4:0] key_data,
  input  logic       ear_in,
  output logic [7:0] dout,
  output logic       rd_cs,
  output logic [2:0] border,
  output logic       mic,
  output logic       ear,
  output logic       port_wr,
  output logic       audio_out
);

  // The summed level must fit in 8 bits, so the DAC adder cannot overflow.
  generate
    if (EAR_LEVEL + MIC_LEVEL + TAPE_LEVEL > 255) begin : g_level_check
      $error("ula_port: EAR_LEVEL + MIC_LEVEL + TAPE_LEVEL exceeds 255");
    end
  endgenerate

  logic       wr_req;
  logic       wr_strobe;
  logic       wr_q;
  logic [2:0] border_q, border_d;
  logic       mic_q, mic_d;
  logic       ear_q, ear_d;
  logic       port_wr_q, port_wr_d;
  logic       ear_meta_q;
  logic       ear_sync_q;
  logic       audio_q, audio_d;
  logic       unused_din;

  assign unused_din = ^din[7:5];

  assign wr_req = ~n_iorq & ~n_wr & ~addr0;
  assign rd_cs  = ~n_iorq & ~n_rd & ~addr0;

  // Only the first clk of a write cycle counts. wr_q resets to 1, so a write
  // that is already active when reset releases is ignored until WR goes high.
  assign wr_strobe = wr_req & ~wr_q;

  always_comb begin
    border_d  = border_q;
    mic_d     = mic_q;
    ear_d     = ear_q;
    port_wr_d = 1'b0;
    if (wr_strobe) begin
      border_d  = din[2:0];
      mic_d     = din[3];
      ear_d     = din[4];
      port_wr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q       <= 1'b1;
      border_q   <= 3'd0;
      mic_q      <= 1'b0;
      ear_q      <= 1'b0;
      port_wr_q  <= 1'b0;
      ear_meta_q <= 1'b0;
      ear_sync_q <= 1'b0;
      audio_q    <= 1'b0;
    end else begin
      wr_q       <= wr_req;
      border_q   <= border_d;
      mic_q      <= mic_d;
      ear_q      <= ear_d;
      port_wr_q  <= port_wr_d;
      ear_meta_q <= ear_in;
      ear_sync_q <= ear_meta_q;
      audio_q    <= audio_d;
    end
  end

`ifdef ULA_SIGMA_DELTA_EN
  // First-order sigma-delta DAC: the carry out of an 8-bit phase accumulator
  // has a density of level/256.
  logic [7:0] level;
  logic [8:0] acc_q, acc_d;

  always_comb begin
    level = (ear_q      ? 8'(EAR_LEVEL)  : 8'd0)
          + (mic_q      ? 8'(MIC_LEVEL)  : 8'd0)
          + (ear_sync_q ? 8'(TAPE_LEVEL) : 8'd0);
    acc_d   = {1'b0, acc_q[7:0]} + {1'b0, level};
    audio_d = acc_q[8];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= 9'd0;
    end else begin
      acc_q <= acc_d;
    end
  end
`else
  // Plain beeper: the EAR latch, toggled by tape input only while MIC is set.
  always_comb begin
    audio_d = ear_q ^ (mic_q & ear_sync_q);
  end
`endif

  assign dout      = {1'b1, ear_sync_q, 1'b1, key_data};
  assign border    = border_q;
  assign mic       = mic_q;
  assign ear       = ear_q;
  assign port_wr   = port_wr_q;
  assign audio_out = audio_q;

endmodule

// File: doc/ula_port.md
# ula_port

ULA I/O port block for the Spectrum core: decodes Z80 I/O cycles to port 0xFE (any even address), holds border colour and MIC/EAR output latches, and assembles read data from the keyboard matrix and tape EAR input. It sits between the CPU bus and the keyboard / video / audio pins. It feeds `border` to the video stage and produces a 1-bit audio stream for the beeper pin. Everything runs in the system `clk` domain; the CPU strobes are sampled as level signals, because `cpuClock` is a divided enable-like clock.

## Interface
- `EAR_LEVEL`, 192: DAC contribution of the EAR latch (8-bit units).
- `MIC_LEVEL`, 32: DAC contribution of the MIC latch.
- `TAPE_LEVEL`, 16: DAC contribution of the synchronised tape input.
  - Elaboration-time check: `EAR_LEVEL + MIC_LEVEL + TAPE_LEVEL` ≤ 255, else `$error`.
- `clk`  in  1  system clock (25 MHz domain).
- `reset_n`  in  1  reset; asynchronous assert, active-low.
- `n_iorq`  in  1  Z80 IORQ, active-low.
- `n_rd`  in  1  Z80 RD, active-low.
- `n_wr`  in  1  Z80 WR, active-low.
- `addr0`  in  1  CPU address bit 0.
- `din`  in  8  CPU data out.
- `key_data`  in  5  keyboard matrix columns for the current address, active-low.
- `ear_in`  in  1  asynchronous tape input.
- `dout`  out  8  read data for port 0xFE.
- `rd_cs`  out  1  high while a port-0xFE read is in progress; used by the top-level data mux.
- `border`  out  3  border colour latch (`din[2:0]`).
- `mic`  out  1  MIC latch (`din[3]`).
- `ear`  out  1  EAR/beeper latch (`din[4]`).
- `port_wr`  out  1  one-`clk` pulse per accepted port write.
- `audio_out`  out  1  sigma-delta audio bitstream.

## Operation
- Decode:
  - `wr_req = !n_iorq & !n_wr & !addr0`.
  - `rd_cs = !n_iorq & !n_rd & !addr0`. Combinational, no latency.
- Write edge detect:
  - Register `wr_q <= wr_req`. Strobe is `wr_req & !wr_q`.
  - On the strobe edge: `border <= din[2:0]`, `mic <= din[3]`, `ear <= din[4]`, `port_wr <= 1`.
  - Otherwise `port_wr <= 0`.
  - One update per IORQ write cycle, however many `clk` cycles WR stays low.
- Read data: `dout = {1'b1, ear_sync, 1'b1, key_data}`. Combinational from `key_data` and the registered `ear_sync`.
- EAR input: two-flop synchroniser `ear_in -> ear_meta -> ear_sync`.
- Audio level: `level = (ear?EAR_LEVEL:0) + (mic?MIC_LEVEL:0) + (ear_sync?TAPE_LEVEL:0)`.
  - 8-bit; cannot overflow given the parameter check.
- DAC: 9-bit accumulator updated every `clk`, `acc <= {1'b0, acc[7:0]} + level`. `audio_out` is the registered `acc[8]`.
- Reset values (all asynchronous to `reset_n` low):
  - `border=0`, `mic=0`, `ear=0`, `port_wr=0`, `audio_out=0`, `acc=0`, `ear_meta=0`, `ear_sync=0`.
  - `wr_q=1`, so a write already active when reset releases is ignored.
- Boundary conditions:
  - Odd-address I/O is ignored.
  - MREQ cycles are ignored.
  - Read and write asserted together: the write is accepted, and `dout` is still driven.
  - Reset asserted mid-write: latches clear immediately. No strobe is generated until `wr_req` has been seen low at least once after release.

## Timing
- Write: latches and `port_wr` change at the first rising `clk` where `wr_req=1`. Visible in the following cycle.
- Back-to-back writes need `wr_req` low for ≥1 `clk` sample between them. The Z80 guarantees this.
- `ear_in` to `dout[6]`: 2 `clk` cycles.
- `ear_in` to DAC level: 2 cycles to `ear_sync`, then 1 cycle of `acc`, then 1 cycle to `audio_out`.
- Latch change to first affected `audio_out` bit: 2 `clk` cycles.
- DAC density: over any 256 consecutive cycles with constant `level` L, `audio_out` has exactly L ones (±1).

## Configuration
- `ULA_SIGMA_DELTA_EN`
  - Defined: the accumulator DAC described above.
  - Undefined: accumulator and level adder are removed, and `audio_out` is a register of `ear ^ (mic & ear_sync)`, registered 1 `clk` after the latch. Port decode and read data are identical in both builds.

## Test plan
- Reset, then drive IORQ+WR with `addr0=0`, `din=8'h15` for 5 `clk` cycles -> `border=3'd5`, `ear=1`, `mic=0`; `port_wr` high for exactly one cycle.
- Same write but `addr0=1` -> `border`, `ear`, `mic` unchanged; `port_wr` never pulses.
- IORQ+RD, `addr0=0`, `key_data=5'h1E`, `ear_in` held 1 for ≥3 cycles -> `rd_cs=1`, `dout=8'hFE`; with `ear_in=0` -> `dout=8'hBE`.
- (`ULA_SIGMA_DELTA_EN`) Write `din=8'h10` (EAR only), count `audio_out` over 256 cycles after settling -> 192±1 ones. Write `8'h00` -> 0 ones.
- Assert `reset_n` low while WR is held low after a write of `8'h07`, then release with WR still low -> `border=0` immediately, no `port_wr` pulse until WR deasserts and a new write occurs.
- Two writes `8'h01` then `8'h06` separated by 1 low cycle of `wr_req` -> two `port_wr` pulses, final `border=3'd6`.
